// File: rtl/seg_scan_ctrl.sv
// Multiplexed 4-digit 7-segment and LED scan controller.
// Digits and LEDs are snapshotted at frame start so mid-frame input changes never tear the display.
//
// state | meaning
// IDLE  | display blanked, waiting for en
// LOAD  | one cycle: capture shadows, restart prescaler/digit, pulse frame_start
// SCAN  | drive one digit per SCAN_DIV cycles, digits 0..3, then back to LOAD
module seg_scan_ctrl #(
    parameter int SCAN_DIV     = 4,
    parameter int BLINK_FRAMES = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] disp0,
    input  logic [7:0] disp1,
    input  logic [7:0] disp2,
    input  logic [7:0] disp3,
    input  logic [7:0] led_in,
    input  logic       blink,
    output logic [7:0] seg,
    output logic [3:0] an,
    output logic [7:0] led_out,
    output logic       frame_start
);

    typedef enum logic [1:0] {IDLE, LOAD, SCAN} state_t;

    localparam logic [15:0] DIV_TC = 16'(SCAN_DIV - 1);
    localparam logic [7:0]  FRM_TC = 8'(BLINK_FRAMES - 1);

    state_t          state, state_nxt;
    logic [15:0]     presc;
    logic [1:0]      digit;
    logic [7:0]      frame_cnt;
    logic            phase;
    logic            blank_phase;
    logic [3:0][7:0] sh_disp;
    logic [7:0]      sh_led;
    logic            tick;

    assign tick = (state == SCAN) && (presc == DIV_TC);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (en) state_nxt = LOAD;
            LOAD:    state_nxt = SCAN;
            SCAN:    if (tick && digit == 2'd3) state_nxt = LOAD;
            default: state_nxt = IDLE;
        endcase
        if (!en) state_nxt = IDLE;
    end

    // blank_phase freezes the blink phase for the whole frame it was loaded with,
    // so a frame is blanked only after BLINK_FRAMES complete frames have been shown.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc       <= '0;
            digit       <= '0;
            frame_cnt   <= '0;
            phase       <= 1'b0;
            blank_phase <= 1'b0;
            sh_disp     <= '0;
            sh_led      <= '0;
        end else if (state == LOAD) begin
            presc       <= '0;
            digit       <= '0;
            sh_disp     <= {disp3, disp2, disp1, disp0};
            sh_led      <= led_in;
            blank_phase <= phase;
            if (frame_cnt == FRM_TC) begin
                frame_cnt <= '0;
                phase     <= ~phase;
            end else begin
                frame_cnt <= frame_cnt + 8'd1;
            end
        end else if (state == SCAN) begin
            if (tick) begin
                presc <= '0;
                digit <= digit + 2'd1;
            end else begin
                presc <= presc + 16'd1;
            end
        end
    end

    always_comb begin
        an          = 4'b1111;
        seg         = 8'h00;
        led_out     = 8'h00;
        frame_start = 1'b0;
        case (state)
            LOAD: frame_start = 1'b1;
            SCAN: begin
                seg = sh_disp[digit];
                if (!(blink && blank_phase)) begin
                    an      = ~(4'b0001 << digit);
                    led_out = sh_led;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 4: clk cycles per digit slot; legal range 1..65535.
REQ-002 SHALL have parameter BLINK_FRAMES, default 8: frames per blink half-period; legal range 1..255.
REQ-003 SHALL have port clk, input, 1: clock; all state changes on rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port en, input, 1: scan enable; 0 blanks the display.
REQ-006 SHALL have ports disp0, disp1, disp2, disp3, input, 8 each: segment patterns; bit7 = dp, bits6:0 = g..a; disp3 is the leftmost digit.
REQ-007 SHALL have port led_in, input, 8: LED pattern.
REQ-008 SHALL have port blink, input, 1: 1 = flash digits and LEDs.
REQ-009 SHALL have port seg, output, 8: shared segment bus, active-high.
REQ-010 SHALL have port an, output, 4: digit enables, active-low; an[i] selects dispi.
REQ-011 SHALL have port led_out, output, 8: LED drive.
REQ-012 SHALL have port frame_start, output, 1: one-cycle pulse per frame.

Function
REQ-013 SHALL implement a 3-state FSM: IDLE, LOAD, SCAN.
REQ-014 IDLE: an=4'b1111, seg=0, led_out=0, frame_start=0; en=1 -> LOAD next cycle.
REQ-015 LOAD lasts exactly one cycle and performs the following:
- captures disp0..disp3 and led_in into shadow registers;
- clears the prescaler and the digit index;
- sets frame_start=1, an=4'b1111, seg=0;
- goes to SCAN next cycle.
REQ-016 SCAN: prescaler counts 0..SCAN_DIV-1; tick = (prescaler == SCAN_DIV-1).
- On tick the prescaler wraps to 0.
- On tick the digit index advances 0->1->2->3.
- On tick with digit index 3, the FSM goes to LOAD instead of wrapping the index.
REQ-017 In SCAN: an = ~(4'b0001 << digit), seg = shadow[digit], led_out = LED shadow.
REQ-018 Frame length SHALL be 1 + 4*SCAN_DIV cycles (17 at the defaults).
REQ-019 en=0 in any state SHALL force IDLE on the next edge, including mid-frame; shadows retain their values.
REQ-020 Inputs changing mid-frame SHALL NOT affect outputs until the next LOAD (no tearing).
REQ-021 Blink logic:
- a frame counter 0..BLINK_FRAMES-1 increments on each LOAD;
- at terminal count it wraps to 0 and toggles blink phase;
- frame counter and phase advance regardless of blink.
REQ-022 blink=1 and phase=1 in SCAN SHALL force an=4'b1111 and led_out=0; seg still follows the shadow. blink is sampled combinationally each cycle.
REQ-023 Outputs SHALL depend only on registered state plus the blink input; no path from disp*/led_in to outputs except through the shadows.
REQ-024 SCAN_DIV=1 SHALL give one cycle per digit with no prescaler stall.
REQ-025 Exactly one an bit SHALL be low in any SCAN cycle with blanking inactive; never more than one.

Reset
REQ-026 rst=1 SHALL immediately force the following, regardless of clk:
- FSM to IDLE;
- prescaler, digit index, frame counter and blink phase to 0;
- shadows to 0;
- outputs to an=4'b1111, seg=0, led_out=0, frame_start=0.
REQ-027 After rst is released with en=1, LOAD SHALL occur on the first rising edge.

Verification
REQ-028 Basic scan:
- stimulus: defaults, en=1, disp0..3=8'h3F/06/5B/4F, led_in=8'h99;
- response: frame_start at cycle 0; then an=1110/seg=3F for 4 cycles, an=1101/seg=06, an=1011/seg=5B, an=0111/seg=4F; led_out=99; frame_start again at cycle 17.
REQ-029 No tearing: changing disp1 from 8'h06 to 8'h7F during the digit-2 slot -> digit 1 shows 06 for the rest of the frame and 7F from the next frame.
REQ-030 Blink: BLINK_FRAMES=2, blink=1 -> frames 0-1 scan normally; frames 2-3 give an=1111, led_out=0; frames 4-5 normal.
REQ-031 Disable: en dropped mid-SCAN -> next cycle an=1111, seg=0, led_out=0; raising en again -> LOAD then digit 0.
REQ-032 Reset: rst asserted mid-frame between clock edges -> outputs reach their reset values immediately; after release, frame_start on the first edge.
REQ-033 SCAN_DIV=1: the digit advances every cycle; frame_start period is 5 cycles.
